aes_key_expand128: RTL and testbench

//   Sequential AES-128 key schedule (FIPS-197 sec. 5.2). Latches a 128-bit cipher key, then

---
 rtl/aes_key_expand128_if.sv | 28 ++
 rtl/aes_key_expand128.sv | 132 +++++++++++++
 tb/tb_aes_key_expand128.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_expand128_if.sv
// ---------------------------------------------------------------------------
// aes_key_expand128_if : start/key request and round-key valid/ready stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface aes_key_expand128_if;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         busy;
    logic         done;

    modport master (
        output start, key_in, rk_ready,
        input  rk_valid, rk_index, round_key, busy, done
    );

    modport slave (
        input  start, key_in, rk_ready,
        output rk_valid, rk_index, round_key, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/aes_key_expand128.sv
// ---------------------------------------------------------------------------
// aes_key_expand128 : sequential AES-128 key schedule, one round key per beat
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aes_key_expand128 #(
    parameter int NUM_ROUNDS = 10
) (
    input  wire logic             clk,
    input  wire logic             rst,
    aes_key_expand128_if.slave    bus
);

    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;
    localparam logic [3:0] c_LAST   = 4'(NUM_ROUNDS);

    // Table entry 0 sits in the top byte, so entry x starts at bit 8*(255-x) = {~x,3'b0}.
    function automatic logic [7:0] f_sbox(input logic [7:0] x);
        return c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    logic [0:0]   r_state;
    logic [0:0]   w_state_nxt;
    logic [127:0] r_round_key;
    logic [3:0]   r_rk_index;
    logic         r_rk_valid;
    logic         r_done;
    logic [7:0]   r_rcon;

    logic         w_accept;
    logic         w_last;
    logic         w_load;
    logic         w_advance;
    logic         w_finish;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [127:0] w_next_key;
    logic [7:0]   w_rcon_nxt;

    assign w_accept = r_rk_valid & bus.rk_ready;
    assign w_last   = (r_rk_index == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.start)          w_state_nxt = S_STREAM;
            S_STREAM: if (w_accept && w_last) w_state_nxt = S_IDLE;
            default:                          w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_advance = 1'b0;
        w_finish  = 1'b0;
        case (r_state)
            S_IDLE:   w_load = bus.start;
            S_STREAM: begin
                w_advance = w_accept & ~w_last;
                w_finish  = w_accept &  w_last;
            end
            default: ;
        endcase
    end

    // Round function on the last word: RotWord, SubWord, then fold in rcon.
    assign w_rot = {r_round_key[23:0], r_round_key[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        assign w_sub[8*g +: 8] = f_sbox(w_rot[8*g +: 8]);
    end

    assign w_t = w_sub ^ {r_rcon, 24'h0};
    assign w_next_key[127:96] = r_round_key[127:96] ^ w_t;
    assign w_next_key[95:64]  = r_round_key[95:64]  ^ w_next_key[127:96];
    assign w_next_key[63:32]  = r_round_key[63:32]  ^ w_next_key[95:64];
    assign w_next_key[31:0]   = r_round_key[31:0]   ^ w_next_key[63:32];

    assign w_rcon_nxt = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_round_key <= '0;
            r_rk_index  <= '0;
            r_rk_valid  <= 1'b0;
            r_done      <= 1'b0;
            r_rcon      <= 8'h01;
        end else begin
            r_done <= w_finish;
            if (w_load) begin
                r_round_key <= bus.key_in;
                r_rk_index  <= '0;
                r_rk_valid  <= 1'b1;
                r_rcon      <= 8'h01;
            end else if (w_advance) begin
                r_round_key <= w_next_key;
                r_rk_index  <= r_rk_index + 4'd1;
                r_rcon      <= w_rcon_nxt;
            end else if (w_finish) begin
                r_rk_valid  <= 1'b0;
            end
        end
    end

    assign bus.rk_valid  = r_rk_valid;
    assign bus.rk_index  = r_rk_index;
    assign bus.round_key = r_round_key;
    assign bus.done      = r_done;
    assign bus.busy      = (r_state == S_STREAM);

endmodule

`default_nettype wire

// File: tb/tb_aes_key_expand128.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expand128 : directed-vector bench for the AES-128 key schedule
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aes_key_expand128;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    aes_key_expand128_if ifc ();

    aes_key_expand128 #(.NUM_ROUNDS(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    localparam logic [127:0] c_KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic [127:0] exp1 [0:10];
    int n_pass  = 0;
    int n_total = 0;

    task automatic test_reset();
        rst = 1'b1; ifc.start = 1'b1; ifc.key_in = c_KEY1; ifc.rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_total++; if (ifc.rk_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifc.rk_valid); else n_pass++;
        n_total++; if (ifc.rk_index !== 4'd0) $display("FAIL reset_index: got %0d want 0", ifc.rk_index); else n_pass++;
        n_total++; if (ifc.round_key !== 128'h0) $display("FAIL reset_key: got %h want 0", ifc.round_key); else n_pass++;
        n_total++; if (ifc.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", ifc.busy); else n_pass++;
        n_total++; if (ifc.done !== 1'b0) $display("FAIL reset_done: got %b want 0", ifc.done); else n_pass++;
        rst = 1'b0; ifc.start = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vector1();
        ifc.key_in = c_KEY1; ifc.start = 1'b1; ifc.rk_ready = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            n_total++; if (ifc.rk_valid !== 1'b1 || ifc.busy !== 1'b1 || ifc.done !== 1'b0)
                $display("FAIL v1_ctrl[%0d]: got valid=%b busy=%b done=%b want 1 1 0", i, ifc.rk_valid, ifc.busy, ifc.done);
            else n_pass++;
            n_total++; if (ifc.rk_index !== 4'(i)) $display("FAIL v1_index[%0d]: got %0d want %0d", i, ifc.rk_index, i); else n_pass++;
            n_total++; if (ifc.round_key !== exp1[i]) $display("FAIL v1_key[%0d]: got %h want %h", i, ifc.round_key, exp1[i]); else n_pass++;
            @(negedge clk);
        end
        n_total++; if (ifc.done !== 1'b1 || ifc.rk_valid !== 1'b0 || ifc.busy !== 1'b0)
            $display("FAIL v1_done: got done=%b valid=%b busy=%b want 1 0 0", ifc.done, ifc.rk_valid, ifc.busy);
        else n_pass++;
        n_total++; if (ifc.rk_index !== 4'd10 || ifc.round_key !== exp1[10])
            $display("FAIL v1_hold: got idx=%0d key=%h want 10 %h", ifc.rk_index, ifc.round_key, exp1[10]);
        else n_pass++;
        @(negedge clk);
        n_total++; if (ifc.done !== 1'b0) $display("FAIL v1_done_pulse: got %b want 0", ifc.done); else n_pass++;
    endtask

    task automatic test_zero_key();
        ifc.key_in = 128'h0; ifc.start = 1'b1; ifc.rk_ready = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            if (i == 0) begin
                n_total++; if (ifc.round_key !== 128'h0) $display("FAIL zk_key0: got %h want 0", ifc.round_key); else n_pass++;
            end else if (i == 1) begin
                n_total++; if (ifc.round_key !== 128'h62636363626363636263636362636363)
                    $display("FAIL zk_key1: got %h want 62636363626363636263636362636363", ifc.round_key);
                else n_pass++;
            end else if (i == 10) begin
                n_total++; if (ifc.round_key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e)
                    $display("FAIL zk_key10: got %h want b4ef5bcb3e92e21123e951cf6f8f188e", ifc.round_key);
                else n_pass++;
            end
            @(negedge clk);
        end
        n_total++; if (ifc.done !== 1'b1) $display("FAIL zk_done: got %b want 1", ifc.done); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        int exp_i = 0;
        int cyc = 0;
        bit r;
        ifc.key_in = c_KEY1; ifc.start = 1'b1; ifc.rk_ready = 1'b0;
        @(negedge clk);
        ifc.start = 1'b0;
        while (exp_i <= 10 && cyc < 300) begin
            n_total++; if (ifc.rk_valid !== 1'b1 || ifc.rk_index !== 4'(exp_i) || ifc.round_key !== exp1[exp_i])
                $display("FAIL stall_beat[%0d]: got valid=%b idx=%0d key=%h want 1 %0d %h",
                         exp_i, ifc.rk_valid, ifc.rk_index, ifc.round_key, exp_i, exp1[exp_i]);
            else n_pass++;
            r = 1'($urandom_range(0, 1));
            ifc.rk_ready = r;
            if (r) exp_i++;
            @(negedge clk);
            cyc++;
        end
        n_total++; if (cyc >= 300) $display("FAIL stall_timeout: got %0d beats want 11", exp_i); else n_pass++;
        n_total++; if (ifc.done !== 1'b1 || ifc.rk_valid !== 1'b0)
            $display("FAIL stall_done: got done=%b valid=%b want 1 0", ifc.done, ifc.rk_valid);
        else n_pass++;
        ifc.rk_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        ifc.key_in = c_KEY1; ifc.start = 1'b1; ifc.rk_ready = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            n_total++; if (ifc.rk_index !== 4'(i) || ifc.round_key !== exp1[i])
                $display("FAIL ign_key[%0d]: got idx=%0d key=%h want %0d %h", i, ifc.rk_index, ifc.round_key, i, exp1[i]);
            else n_pass++;
            if (i == 4) begin ifc.start = 1'b1; ifc.key_in = 128'h00112233445566778899aabbccddeeff; end
            else        ifc.start = 1'b0;
            @(negedge clk);
        end
        n_total++; if (ifc.done !== 1'b1) $display("FAIL ign_done: got %b want 1", ifc.done); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        ifc.key_in = c_KEY1; ifc.start = 1'b1; ifc.rk_ready = 1'b1;
        @(negedge clk);
        ifc.start = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        n_total++; if (ifc.rk_index !== 4'd6) $display("FAIL rm_at6: got %0d want 6", ifc.rk_index); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (ifc.rk_valid !== 1'b0 || ifc.rk_index !== 4'd0 || ifc.round_key !== 128'h0 || ifc.busy !== 1'b0 || ifc.done !== 1'b0)
            $display("FAIL rm_clear: got valid=%b idx=%0d key=%h busy=%b done=%b want all 0",
                     ifc.rk_valid, ifc.rk_index, ifc.round_key, ifc.busy, ifc.done);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_total++; if (ifc.done !== 1'b0 || ifc.busy !== 1'b0) $display("FAIL rm_no_done: got done=%b busy=%b want 0 0", ifc.done, ifc.busy); else n_pass++;
        end
        test_vector1();
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        ifc.key_in = c_KEY1; ifc.start = 1'b1; ifc.rk_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= 10; i++) begin
            n_total++; if (ifc.rk_index !== 4'(i) || ifc.round_key !== exp1[i])
                $display("FAIL b2b_run1[%0d]: got idx=%0d key=%h want %0d %h", i, ifc.rk_index, ifc.round_key, i, exp1[i]);
            else n_pass++;
            @(negedge clk);
        end
        n_total++; if (ifc.done !== 1'b1 || ifc.rk_valid !== 1'b0)
            $display("FAIL b2b_gap: got done=%b valid=%b want 1 0", ifc.done, ifc.rk_valid);
        else n_pass++;
        @(negedge clk);
        n_total++; if (ifc.rk_valid !== 1'b1 || ifc.rk_index !== 4'd0 || ifc.round_key !== exp1[0] || ifc.done !== 1'b0)
            $display("FAIL b2b_run2_0: got valid=%b idx=%0d key=%h done=%b want 1 0 %h 0",
                     ifc.rk_valid, ifc.rk_index, ifc.round_key, ifc.done, exp1[0]);
        else n_pass++;
        ifc.start = 1'b0;
        @(negedge clk);
        n_total++; if (ifc.rk_index !== 4'd1 || ifc.round_key !== exp1[1])
            $display("FAIL b2b_run2_1: got idx=%0d key=%h want 1 %h", ifc.rk_index, ifc.round_key, exp1[1]);
        else n_pass++;
        while (ifc.done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        n_total++; if (ifc.done !== 1'b1 || ifc.round_key !== exp1[10])
            $display("FAIL b2b_run2_end: got done=%b key=%h want 1 %h", ifc.done, ifc.round_key, exp1[10]);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        exp1[0]  = c_KEY1;
        exp1[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp1[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp1[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp1[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp1[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp1[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp1[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp1[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp1[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp1[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        rst = 1'b1; ifc.start = 1'b0; ifc.key_in = '0; ifc.rk_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_vector1();
        test_zero_key();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
